// File: rtl/crt_garner_sequencer_if.sv
// Handshake bundle for crt_garner_sequencer: start/busy control, the input pair
// stream, the shared modular-inverse port and the result stream.
// The sequencer connects to the slave view. The environment (residue source,
// inverse unit and result consumer) connects to the master view.
interface crt_garner_sequencer_if #(
    parameter int unsigned W  = 4,
    parameter int unsigned RW = 12
);
    logic          start;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_m;
    logic [W-1:0]  in_x;
    logic          inv_req;
    logic [W-1:0]  inv_a;
    logic [W-1:0]  inv_m;
    logic          inv_done;
    logic [W-1:0]  inv_result;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] result;
    logic [RW-1:0] modulus;
    logic          error;

    modport master (
        output start, in_valid, in_m, in_x, inv_done, inv_result, out_ready,
        input  busy, in_ready, inv_req, inv_a, inv_m, out_valid, result, modulus, error
    );

    modport slave (
        input  start, in_valid, in_m, in_x, inv_done, inv_result, out_ready,
        output busy, in_ready, inv_req, inv_a, inv_m, out_valid, result, modulus, error
    );
endinterface

// File: rtl/crt_garner_sequencer.sv
// Iterative CRT reconstruction (Garner's method) around one shared external
// modular-inverse unit. It keeps a running (X, M) pair and folds in each new
// (m, x) pair.
// Optional macro CRT_INV_TIMEOUT_EN adds an inverse-wait watchdog. The watchdog
// aborts with an error after TIMEOUT cycles.
module crt_garner_sequencer #(
    parameter int unsigned W       = 4,
    parameter int unsigned K       = 3,
    parameter int unsigned RW      = W * K,
    parameter int unsigned TIMEOUT = 64
) (
    input logic                   clk,
    input logic                   reset,
    crt_garner_sequencer_if.slave bus
);
    localparam int unsigned CW = $clog2(K + 1);

    typedef enum logic [2:0] {
        StIdle, StWaitIn, StReduce, StInvReq, StInvWait, StUpdate, StDone
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] x_acc_q, x_acc_d;
    logic [RW-1:0] m_acc_q, m_acc_d;
    logic [W-1:0]  m_q, m_d;
    logic [W-1:0]  xin_q, xin_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  d_q, d_d;
    logic [W-1:0]  r_q, r_d;
    logic          err_q, err_d;

    // Datapath terms. All arithmetic is done at RW bits, so no product can wrap.
    logic [RW-1:0] m_ext, a_calc, xr_calc, xacc_r_calc, d_calc, chk_calc, t_calc;
    logic [RW-1:0] x_new, m_new, first_x;
    logic          check_ok;

    assign m_ext       = RW'(m_q);
    assign a_calc      = m_acc_q % m_ext;
    assign xr_calc     = RW'(xin_q) % m_ext;
    assign xacc_r_calc = x_acc_q % m_ext;
    assign d_calc      = (xr_calc + m_ext - xacc_r_calc) % m_ext;
    assign chk_calc    = (RW'(a_q) * RW'(bus.inv_result)) % m_ext;
    assign check_ok    = (chk_calc == RW'(1));
    assign t_calc      = (RW'(d_q) * RW'(r_q)) % m_ext;
    assign x_new       = x_acc_q + m_acc_q * t_calc;
    assign m_new       = m_acc_q * m_ext;
    assign first_x     = RW'(bus.in_x) % RW'(bus.in_m);

`ifdef CRT_INV_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_q;

    // Watchdog: count cycles spent in INV_WAIT, restart from zero elsewhere
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= '0;
        end else if (state_q == StInvWait) begin
            wait_q <= wait_q + TW'(1);
        end else begin
            wait_q <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            x_acc_q <= '0;
            m_acc_q <= '0;
            m_q     <= '0;
            xin_q   <= '0;
            a_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_acc_q <= x_acc_d;
            m_acc_q <= m_acc_d;
            m_q     <= m_d;
            xin_q   <= xin_d;
            a_q     <= a_d;
            d_q     <= d_d;
            r_q     <= r_d;
            err_q   <= err_d;
        end
    end

    // Next-state sequencing and register updates for each fold step
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_acc_d = x_acc_q;
        m_acc_d = m_acc_q;
        m_d     = m_q;
        xin_d   = xin_q;
        a_d     = a_q;
        d_d     = d_q;
        r_d     = r_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StWaitIn;
                    cnt_d   = '0;
                    x_acc_d = '0;
                    m_acc_d = '0;
                    err_d   = 1'b0;
                end
            end
            StWaitIn: begin
                if (bus.in_valid) begin
                    if (bus.in_m < W'(2)) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (cnt_q == '0) begin
                        x_acc_d = first_x;
                        m_acc_d = RW'(bus.in_m);
                        cnt_d   = CW'(1);
                    end else begin
                        m_d     = bus.in_m;
                        xin_d   = bus.in_x;
                        state_d = StReduce;
                    end
                end
            end
            StReduce: begin
                a_d     = a_calc[W-1:0];
                d_d     = d_calc[W-1:0];
                state_d = StInvReq;
            end
            StInvReq: begin
                state_d = StInvWait;
            end
            StInvWait: begin
                if (bus.inv_done) begin
                    if (check_ok) begin
                        r_d     = bus.inv_result;
                        state_d = StUpdate;
                    end else begin
                        // Not coprime: the returned value cannot be an inverse.
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
`ifdef CRT_INV_TIMEOUT_EN
                else if (wait_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
`endif
            end
            StUpdate: begin
                x_acc_d = x_new;
                m_acc_d = m_new;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q + CW'(1) == CW'(K)) ? StDone : StWaitIn;
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.in_ready  = (state_q == StWaitIn);
    assign bus.inv_req   = (state_q == StInvReq);
    assign bus.inv_a     = a_q;
    assign bus.inv_m     = m_q;
    assign bus.out_valid = (state_q == StDone);
    assign bus.error     = bus.out_valid & err_q;
    assign bus.result    = (bus.out_valid && !err_q) ? x_acc_q : '0;
    assign bus.modulus   = (bus.out_valid && !err_q) ? m_acc_q : '0;
endmodule
